// File: rtl/pc_branch_unit_pkg.sv
// Shared constants for the VeSPA PC / branch resolution stage:
// condition-code bit positions, branch condition encodings and flush counter width.
package pc_branch_unit_pkg;

  // Bit positions inside the {C,Z,N,V} condition-code bus
  localparam int CC_C = 3;
  localparam int CC_Z = 2;
  localparam int CC_N = 1;
  localparam int CC_V = 0;

  // Flush counter width; bounds FLUSH_CYCLES to 1..7
  localparam int FLUSH_CNT_W = 3;

  // Base condition selected by sel[2:0]; sel[3] inverts the base
  typedef enum logic [2:0] {
    BASE_TRUE = 3'b000,
    BASE_NC   = 3'b001,
    BASE_NV   = 3'b010,
    BASE_Z    = 3'b011,
    BASE_GE   = 3'b100,
    BASE_GT   = 3'b101,
    BASE_NN   = 3'b110,
    BASE_RSVD = 3'b111
  } cond_base_e;

  // Full 4-bit branch condition encodings
  typedef enum logic [3:0] {
    COND_BRA = 4'b0000,
    COND_BCC = 4'b0001,
    COND_BVC = 4'b0010,
    COND_BEQ = 4'b0011,
    COND_BGE = 4'b0100,
    COND_BGT = 4'b0101,
    COND_BPL = 4'b0110,
    COND_BNV = 4'b1000,
    COND_BCS = 4'b1001,
    COND_BVS = 4'b1010,
    COND_BNE = 4'b1011,
    COND_BLT = 4'b1100,
    COND_BLE = 4'b1101,
    COND_BMI = 4'b1110
  } cond_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational evaluation of the VeSPA branch condition from the
// condition field and the ALU's registered condition codes.
module branch_cond_eval
  import pc_branch_unit_pkg::*;
(
  input  logic [3:0] i_CondSel,
  input  logic [3:0] i_CondCodes,
  output logic       o_CondTrue
);

  cond_base_e w_Base;
  logic       w_BaseTrue;
  logic       w_C;
  logic       w_Z;
  logic       w_N;
  logic       w_V;

  assign w_Base = cond_base_e'(i_CondSel[2:0]);
  assign w_C    = i_CondCodes[CC_C];
  assign w_Z    = i_CondCodes[CC_Z];
  assign w_N    = i_CondCodes[CC_N];
  assign w_V    = i_CondCodes[CC_V];

  // Select the un-inverted base condition
  always_comb begin
    w_BaseTrue = 1'b0;
    case (w_Base)
      BASE_TRUE: w_BaseTrue = 1'b1;
      BASE_NC:   w_BaseTrue = ~w_C;
      BASE_NV:   w_BaseTrue = ~w_V;
      BASE_Z:    w_BaseTrue = w_Z;
      BASE_GE:   w_BaseTrue = ~(w_N ^ w_V);
      BASE_GT:   w_BaseTrue = ~w_Z & ~(w_N ^ w_V);
      BASE_NN:   w_BaseTrue = ~w_N;
      default:   w_BaseTrue = 1'b0;
    endcase
  end

  // Reserved base is never taken, even with the invert bit set
  assign o_CondTrue = (w_Base == BASE_RSVD) ? 1'b0 : (w_BaseTrue ^ i_CondSel[3]);

endmodule

// File: rtl/pc_branch_unit.sv
// Fetch PC register with branch/jump redirect and a post-redirect squash
// window. The flush counter is a down-counter; o_Flush mirrors its nonzero state.
module pc_branch_unit
  import pc_branch_unit_pkg::*;
#(
  parameter int                   BUS_WIDTH    = 32,
  parameter int                   OFFSET_WIDTH = 23,
  parameter logic [BUS_WIDTH-1:0] RESET_PC     = '0,
  parameter int                   PC_STEP      = 4,
  parameter int                   FLUSH_CYCLES = 2
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic                    i_Enable,
  input  logic [3:0]              i_CondCodes,
  input  logic                    i_BranchValid,
  input  logic [3:0]              i_CondSel,
  input  logic [BUS_WIDTH-1:0]    i_BranchPC,
  input  logic [OFFSET_WIDTH-1:0] i_BranchOffset,
  input  logic                    i_JumpValid,
  input  logic [BUS_WIDTH-1:0]    i_JumpTarget,
  output logic [BUS_WIDTH-1:0]    o_PC,
  output logic                    o_Taken,
  output logic                    o_Flush
);

  localparam logic [BUS_WIDTH-1:0]   STEP       = BUS_WIDTH'(PC_STEP);
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES);

  logic [BUS_WIDTH-1:0]   r_PC;
  logic                   r_Taken;
  logic                   r_Flush;
  logic [FLUSH_CNT_W-1:0] r_FlushCnt;

  logic                   w_CondTrue;
  logic [BUS_WIDTH-1:0]   w_OffsetExt;
  logic [BUS_WIDTH-1:0]   w_BranchTarget;
  logic                   w_Redirect;
  logic [BUS_WIDTH-1:0]   w_RedirectPC;

  branch_cond_eval u_cond (
    .i_CondSel   (i_CondSel),
    .i_CondCodes (i_CondCodes),
    .o_CondTrue  (w_CondTrue)
  );

  // Target arithmetic wraps modulo 2^BUS_WIDTH
  assign w_OffsetExt    = {{(BUS_WIDTH-OFFSET_WIDTH){i_BranchOffset[OFFSET_WIDTH-1]}}, i_BranchOffset};
  assign w_BranchTarget = i_BranchPC + STEP + w_OffsetExt;

  // Jump takes priority over a simultaneous taken branch
  assign w_Redirect   = i_JumpValid | (i_BranchValid & w_CondTrue);
  assign w_RedirectPC = i_JumpValid ? i_JumpTarget : w_BranchTarget;

  // PC, redirect pulse and squash-window down-counter
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_PC       <= RESET_PC;
      r_Taken    <= 1'b0;
      r_Flush    <= 1'b0;
      r_FlushCnt <= '0;
    end else if (i_Enable) begin
      r_Taken <= 1'b0;
      if (r_FlushCnt != '0) begin
        // Wrong-path instructions: ignore any branch/jump, keep fetching sequentially
        r_FlushCnt <= r_FlushCnt - 1'b1;
        r_Flush    <= (r_FlushCnt != FLUSH_CNT_W'(1));
        r_PC       <= r_PC + STEP;
      end else if (w_Redirect) begin
        r_PC       <= w_RedirectPC;
        r_Taken    <= 1'b1;
        r_FlushCnt <= FLUSH_LOAD;
        r_Flush    <= (FLUSH_LOAD != '0);
      end else begin
        r_PC    <= r_PC + STEP;
        r_Flush <= 1'b0;
      end
    end else begin
      // Frozen pipeline: the pulse still lasts only one cycle
      r_Taken <= 1'b0;
    end
  end

  assign o_PC    = r_PC;
  assign o_Taken = r_Taken;
  assign o_Flush = r_Flush;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Bench for pc_branch_unit: directed scenarios with literal expectations,
// then randomized traffic, all compared against an architectural model every cycle.
module tb_pc_branch_unit;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  cc;
  logic        bv;
  logic [3:0]  sel;
  logic [31:0] bpc;
  logic [22:0] off;
  logic        jv;
  logic [31:0] tgt;
  logic [31:0] pc;
  logic        taken;
  logic        flush;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  // Architectural model state
  logic [31:0] m_pc     = 32'h0;
  int          m_squash = 0;
  bit          m_taken  = 0;

  pc_branch_unit dut (
    .i_Clk          (clk),
    .i_Rst          (rst),
    .i_Enable       (en),
    .i_CondCodes    (cc),
    .i_BranchValid  (bv),
    .i_CondSel      (sel),
    .i_BranchPC     (bpc),
    .i_BranchOffset (off),
    .i_JumpValid    (jv),
    .i_JumpTarget   (tgt),
    .o_PC           (pc),
    .o_Taken        (taken),
    .o_Flush        (flush)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Branch condition by mnemonic; cc = {C,Z,N,V}
  function automatic bit cond_holds(input logic [3:0] s, input logic [3:0] c);
    bit fc, fz, fn, fv;
    fc = c[3]; fz = c[2]; fn = c[1]; fv = c[0];
    case (s)
      4'd0:    return 1;                     // BRA
      4'd8:    return 0;                     // BNV
      4'd1:    return !fc;                   // BCC
      4'd9:    return fc;                    // BCS
      4'd2:    return !fv;                   // BVC
      4'd10:   return fv;                    // BVS
      4'd3:    return fz;                    // BEQ
      4'd11:   return !fz;                   // BNE
      4'd4:    return fn == fv;              // BGE
      4'd12:   return fn != fv;              // BLT
      4'd5:    return !fz && (fn == fv);     // BGT
      4'd13:   return fz || (fn != fv);      // BLE
      4'd6:    return !fn;                   // BPL
      4'd14:   return fn;                    // BMI
      default: return 0;                     // reserved 7 / 15
    endcase
  endfunction

  function automatic logic [31:0] branch_target(input logic [31:0] p, input logic [22:0] o);
    longint ov;
    ov = longint'(o);
    if (o[22]) ov = ov - (longint'(1) << 23);
    return 32'((longint'(p) + 4 + ov) & 64'hFFFF_FFFF);
  endfunction

  // Model update from the inputs presented at each rising edge
  always @(posedge clk) begin
    if (rst) begin
      m_pc = 32'h0; m_squash = 0; m_taken = 0;
    end else if (!en) begin
      m_taken = 0;
    end else if (m_squash > 0) begin
      m_squash = m_squash - 1; m_pc = m_pc + 32'd4; m_taken = 0;
    end else if (jv) begin
      m_pc = tgt; m_squash = 2; m_taken = 1;
    end else if (bv && cond_holds(sel, cc)) begin
      m_pc = branch_target(bpc, off); m_squash = 2; m_taken = 1;
    end else begin
      m_pc = m_pc + 32'd4; m_taken = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_pc", pc, m_pc);
      check("model_taken", {31'b0, taken}, {31'b0, m_taken});
      check("model_flush", {31'b0, flush}, {31'b0, (m_squash > 0)});
    end
  end

  task automatic idle();
    rst = 0; en = 1; bv = 0; jv = 0; sel = 4'h0; cc = 4'h0;
    bpc = 32'h0; off = 23'h0; tgt = 32'h0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic exp3(input string name, input logic [31:0] e_pc, input bit e_tk, input bit e_fl);
    check({name, "_pc"}, pc, e_pc);
    check({name, "_taken"}, {31'b0, taken}, {31'b0, e_tk});
    check({name, "_flush"}, {31'b0, flush}, {31'b0, e_fl});
  endtask

  task automatic do_branch(input logic [3:0] s, input logic [3:0] c,
                           input logic [31:0] p, input logic [22:0] o);
    idle(); bv = 1; sel = s; cc = c; bpc = p; off = o;
    cycle();
    idle();
  endtask

  task automatic do_jump(input logic [31:0] t);
    idle(); jv = 1; tgt = t;
    cycle();
    idle();
  endtask

  initial begin
    idle();
    rst = 1;
    cycle();
    rst = 0;
    chk_en = 1;
    // 1. reset and sequential fetch
    exp3("reset", 32'h0, 0, 0);
    cycle(); exp3("seq1", 32'h4, 0, 0);
    cycle(); exp3("seq2", 32'h8, 0, 0);
    cycle(); exp3("seq3", 32'hC, 0, 0);
    // 2. taken BEQ with squash window
    do_branch(4'b0011, 4'b0100, 32'h100, 23'h10);
    exp3("beq_taken", 32'h114, 1, 1);
    check("model_pin_beq", m_pc, 32'h114);
    cycle(); exp3("beq_fl1", 32'h118, 0, 1);
    cycle(); exp3("beq_fl2", 32'h11C, 0, 0);
    // 3. not-taken BEQ, taken BLT, not-taken BGT
    do_branch(4'b0011, 4'b0000, 32'h100, 23'h10);
    exp3("beq_nt", 32'h120, 0, 0);
    do_branch(4'b1100, 4'b0010, 32'h200, 23'h20);
    exp3("blt_taken", 32'h224, 1, 1);
    cycle(); cycle();
    exp3("blt_after", 32'h22C, 0, 0);
    do_branch(4'b0101, 4'b0100, 32'h300, 23'h40);
    exp3("bgt_nt", 32'h230, 0, 0);
    // 4. branch during flush is ignored
    do_jump(32'h1000);
    exp3("jmp1000", 32'h1000, 1, 1);
    do_branch(4'b0000, 4'b0000, 32'h40, 23'h0);
    exp3("br_in_flush", 32'h1004, 0, 1);
    cycle(); exp3("br_in_flush2", 32'h1008, 0, 0);
    // 5. jump beats branch; target wrap; negative offset; reserved conditions
    idle(); jv = 1; tgt = 32'h2000; bv = 1; sel = 4'b0000; bpc = 32'h500; off = 23'h8;
    cycle(); idle();
    exp3("jmp_wins", 32'h2000, 1, 1);
    cycle(); cycle();
    do_branch(4'b0000, 4'b0000, 32'hFFFF_FFF8, 23'h8);
    exp3("wrap", 32'h4, 1, 1);
    check("model_pin_wrap", m_pc, 32'h4);
    cycle(); cycle();
    exp3("wrap_after", 32'hC, 0, 0);
    do_branch(4'b0000, 4'b0000, 32'h100, 23'h7FFFE0);
    exp3("neg_off", 32'hE4, 1, 1);
    check("model_pin_neg", m_pc, 32'hE4);
    cycle(); cycle();
    do_branch(4'b0111, 4'b1111, 32'h100, 23'h10);
    exp3("rsvd7", 32'hF0, 0, 0);
    do_branch(4'b1111, 4'b0000, 32'h100, 23'h10);
    exp3("rsvd15", 32'hF4, 0, 0);
    // 6. freeze mid-flush, then reset mid-flush
    do_jump(32'h3000);
    exp3("jmp3000", 32'h3000, 1, 1);
    for (int i = 0; i < 3; i++) begin
      idle(); en = 0; jv = 1; tgt = 32'h5000;
      cycle();
      exp3("frozen", 32'h3000, 0, 1);
    end
    idle();
    cycle(); exp3("unfreeze1", 32'h3004, 0, 1);
    cycle(); exp3("unfreeze2", 32'h3008, 0, 0);
    do_jump(32'h4000);
    exp3("jmp4000", 32'h4000, 1, 1);
    idle(); rst = 1; jv = 1; tgt = 32'h6000;
    cycle(); idle();
    exp3("rst_flush", 32'h0, 0, 0);
    cycle(); exp3("rst_after", 32'h4, 0, 0);

    // Randomized traffic checked by the per-cycle compare process
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      en  = ($urandom_range(0, 7) != 0);
      bv  = ($urandom_range(0, 2) == 0);
      jv  = ($urandom_range(0, 9) == 0);
      sel = 4'($urandom);
      cc  = 4'($urandom);
      bpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255))) : $urandom;
      off = 23'($urandom);
      tgt = $urandom;
      cycle();
    end
    idle();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
